// File: rtl/axis_eth_ipv4_extractor.sv
// -----------------------------------------------------------------------------
// axis_eth_ipv4_extractor
//
// Purpose:
//   Takes raw Ethernet frames on an AXI-Stream input. Frames whose EtherType is
//   0x0800 (IPv4) are forwarded with the 14-byte Ethernet header removed. The
//   output is re-aligned so that the first IPv4 header byte sits at tdata[7:0]
//   of the first output beat. All other frames, and runt single-beat frames
//   with no payload, are accepted and discarded.
//
//   Re-alignment uses a hold register H. H keeps bytes 14..BEAT_BYTES-1 of the
//   previous input beat. Each full output beat is {current bytes 0..13, H}, with
//   H in the low bytes. When the last input beat still carries bytes past
//   offset 13, one extra FLUSH beat drains them from H.
//
//   The output is a single registered slot. Input is accepted only when that
//   slot is free or is being drained in the same cycle, which gives a
//   throughput of 1 beat per cycle with no bubble.
//
// Optional feature (define AXIS_IPV4_EXTRACT_STATS_EN):
//   Adds the 32-bit wrapping counters stat_fwd_cnt and stat_drop_cnt. The
//   datapath is the same with or without them.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   s_axis_*       Ethernet frame input (tdata, tkeep, tvalid, tready, tlast)
//   m_axis_*       IPv4 packet output   (tdata, tkeep, tvalid, tready, tlast)
//   stat_fwd_cnt   frames forwarded      (only with AXIS_IPV4_EXTRACT_STATS_EN)
//   stat_drop_cnt  frames dropped        (only with AXIS_IPV4_EXTRACT_STATS_EN)
// -----------------------------------------------------------------------------
module axis_eth_ipv4_extractor #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
`ifdef AXIS_IPV4_EXTRACT_STATS_EN
   ,
   output logic [31:0]           stat_fwd_cnt,
   output logic [31:0]           stat_drop_cnt
`endif
);

   localparam int unsigned HdrBytes    = 14;
   localparam int unsigned HoldBytes   = KEEP_WIDTH - HdrBytes;
   localparam int unsigned HdrBits     = HdrBytes * 8;
   localparam int unsigned HoldBits    = HoldBytes * 8;
   localparam logic [15:0] EthTypeIpv4 = 16'h0800;

   typedef enum logic [1:0] {
      StIdle,
      StFwd,
      StFlush,
      StDrop
   } state_e;

   state_e                 state_q, state_d;
   logic [HoldBits-1:0]    h_q, h_d;
   logic [HoldBytes-1:0]   fkeep_q, fkeep_d;
   logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
   logic [KEEP_WIDTH-1:0]  m_keep_q, m_keep_d;
   logic                   m_last_q, m_last_d;
   logic                   m_valid_q, m_valid_d;
   logic                   rdy_en_q;

   logic [15:0]            eth_type;
   logic                   is_ipv4;
   logic                   long_tail;
   logic                   out_free;
   logic                   s_ready;
   logic                   s_hs;
   logic [HoldBits-1:0]    tail_hold;
   logic [HoldBytes-1:0]   tail_keep;
   logic [DATA_WIDTH-1:0]  merged_data;
   logic [KEEP_WIDTH-1:0]  merged_keep;

   // EtherType is big-endian on the wire: byte 12 is the high byte.
   assign eth_type  = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
   assign is_ipv4   = (eth_type == EthTypeIpv4);
   // tkeep is contiguous from the LSB, so k > 14 is the same as keep[14] set.
   assign long_tail = s_axis_tkeep[HdrBytes];
   assign out_free  = !m_valid_q || m_axis_tready;
   assign s_hs      = s_axis_tvalid && s_ready;

   assign tail_hold   = s_axis_tdata[DATA_WIDTH-1:HdrBits];
   assign tail_keep   = s_axis_tkeep[KEEP_WIDTH-1:HdrBytes];
   assign merged_data = {s_axis_tdata[HdrBits-1:0], h_q};
   assign merged_keep = {s_axis_tkeep[HdrBytes-1:0], {HoldBytes{1'b1}}};

   // rdy_en_q keeps tready low during reset and for the first cycle after it.
   always_comb begin
      s_ready = 1'b0;
      if (rdy_en_q) begin
         unique case (state_q)
            StIdle, StFwd: s_ready = out_free;
            StDrop:        s_ready = 1'b1;
            default:       s_ready = 1'b0;
         endcase
      end
   end

   assign s_axis_tready = s_ready;

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      fkeep_d   = fkeep_q;
      m_valid_d = m_valid_q && !m_axis_tready;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;

      unique case (state_q)
         StIdle: begin
            if (s_hs) begin
               if (!is_ipv4 || (s_axis_tlast && !long_tail)) begin
                  if (!s_axis_tlast) begin
                     state_d = StDrop;
                  end
               end else if (s_axis_tlast) begin
                  // Single-beat IPv4 frame: payload is just the tail bytes.
                  m_valid_d = 1'b1;
                  m_data_d  = {{HdrBits{1'b0}}, tail_hold};
                  m_keep_d  = {{HdrBytes{1'b0}}, tail_keep};
                  m_last_d  = 1'b1;
               end else begin
                  h_d     = tail_hold;
                  state_d = StFwd;
               end
            end
         end

         StFwd: begin
            if (s_hs) begin
               m_valid_d = 1'b1;
               m_data_d  = merged_data;
               if (!s_axis_tlast) begin
                  m_keep_d = '1;
                  m_last_d = 1'b0;
                  h_d      = tail_hold;
               end else if (!long_tail) begin
                  m_keep_d = merged_keep;
                  m_last_d = 1'b1;
                  state_d  = StIdle;
               end else begin
                  // Bytes past offset 13 do not fit this beat; drain them next.
                  m_keep_d = '1;
                  m_last_d = 1'b0;
                  h_d      = tail_hold;
                  fkeep_d  = tail_keep;
                  state_d  = StFlush;
               end
            end
         end

         StFlush: begin
            if (out_free) begin
               m_valid_d = 1'b1;
               m_data_d  = {{HdrBits{1'b0}}, h_q};
               m_keep_d  = {{HdrBytes{1'b0}}, fkeep_q};
               m_last_d  = 1'b1;
               state_d   = StIdle;
            end
         end

         StDrop: begin
            if (s_hs && s_axis_tlast) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         h_q       <= '0;
         fkeep_q   <= '0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         fkeep_q   <= fkeep_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
         rdy_en_q  <= 1'b1;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;

`ifdef AXIS_IPV4_EXTRACT_STATS_EN
   logic        fwd_inc;
   logic        drop_inc;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   // Both counters move on the accepted tlast beat of the frame.
   assign fwd_inc  = s_hs && s_axis_tlast &&
                     (((state_q == StIdle) && is_ipv4 && long_tail) || (state_q == StFwd));
   assign drop_inc = s_hs && s_axis_tlast &&
                     (((state_q == StIdle) && !(is_ipv4 && long_tail)) ||
                      (state_q == StDrop));

   always_comb begin
      fwd_cnt_d  = fwd_cnt_q + {31'd0, fwd_inc};
      drop_cnt_d = drop_cnt_q + {31'd0, drop_inc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         fwd_cnt_q  <= fwd_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign stat_fwd_cnt  = fwd_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_eth_ipv4_extractor.sv
// -----------------------------------------------------------------------------
// tb_axis_eth_ipv4_extractor
//
// Drives a table of Ethernet frames into axis_eth_ipv4_extractor. For each
// frame the expected output beats are built from the table's hand-computed
// beat count and last-beat byte count, with data taken from the frame bytes
// starting at offset 14. A monitor checks every output beat against that
// queue and checks that stalled beats stay stable. A hand-written sequence
// then applies reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_axis_eth_ipv4_extractor;

   localparam int DW = 512;
   localparam int KW = DW / 8;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
`ifdef AXIS_IPV4_EXTRACT_STATS_EN
   logic [31:0]   stat_fwd_cnt;
   logic [31:0]   stat_drop_cnt;
`endif

   axis_eth_ipv4_extractor #(
      .DATA_WIDTH(DW),
      .KEEP_WIDTH(KW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
`ifdef AXIS_IPV4_EXTRACT_STATS_EN
      ,
      .stat_fwd_cnt  (stat_fwd_cnt),
      .stat_drop_cnt (stat_drop_cnt)
`endif
   );

   typedef struct {
      int          len;
      logic [15:0] et;
      int          seed;
      int          pct;
      int          beats;
      int          last_bytes;
      bit          nostall;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   vec_t        vecs [15];
   beat_t       exp_q [$];
   logic [7:0]  fbuf [0:1023];
   int          n_checks = 0;
   int          n_errors = 0;
   int          rdy_pct  = 100;
   int          exp_fwd  = 0;
   int          exp_drop = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Downstream ready, re-drawn every cycle.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
      end
   end

   // Output monitor: stability under stall plus scoreboard compare.
   initial begin
      bit            prev_stall;
      logic [DW-1:0] prev_data;
      logic [KW-1:0] prev_keep;
      logic          prev_last;
      beat_t         e;
      logic [DW-1:0] mask;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_keep  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk(m_axis_tvalid && (m_axis_tdata == prev_data) && (m_axis_tkeep == prev_keep)
                   && (m_axis_tlast == prev_last), "stall_hold", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               chk(exp_q.size() != 0, "unexpected_beat", m_axis_tdata, '0);
               if (exp_q.size() != 0) begin
                  e    = exp_q.pop_front();
                  mask = '0;
                  for (int j = 0; j < KW; j++) mask[8*j +: 8] = {8{e.keep[j]}};
                  chk((m_axis_tdata & mask) == e.data, "beat_data", m_axis_tdata & mask, e.data);
                  chk(m_axis_tkeep == e.keep, "beat_keep", m_axis_tkeep, e.keep);
                  chk(m_axis_tlast == e.last, "beat_last", m_axis_tlast, e.last);
               end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_last  = m_axis_tlast;
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
   endtask

   // Drives one frame; abort_beat >= 0 pulses reset while that beat is offered.
   task automatic send_frame(input int len, input logic [15:0] et, input int seed,
                             input int beats, input int last_bytes, input bit lat_chk,
                             input int abort_beat, output int stalls);
      int    nb;
      int    lat_beat;
      int    budget;
      bit    hs;
      beat_t e;
      stalls = 0;
      for (int i = 0; i < len; i++) fbuf[i] = 8'(seed * 37 + i * 11 + (i >> 4));
      fbuf[12] = et[15:8];
      fbuf[13] = et[7:0];
      if (len > 17) begin
         fbuf[14] = 8'h45;
         fbuf[16] = 8'((len - 14) >> 8);
         fbuf[17] = 8'(len - 14);
      end
      for (int b = 0; b < beats; b++) begin
         int nby;
         nby    = (b == beats - 1) ? last_bytes : KW;
         e.data = '0;
         e.keep = '0;
         for (int j = 0; j < nby; j++) begin
            e.data[8*j +: 8] = fbuf[14 + KW*b + j];
            e.keep[j]        = 1'b1;
         end
         e.last = (b == beats - 1);
         exp_q.push_back(e);
      end
      nb       = (len + KW - 1) / KW;
      lat_beat = (nb == 1) ? 0 : 1;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < KW; j++) begin
            if (KW*b + j < len) begin
               s_axis_tdata[8*j +: 8] = fbuf[KW*b + j];
               s_axis_tkeep[j]        = 1'b1;
            end else begin
               s_axis_tdata[8*j +: 8] = 8'hEE;
               s_axis_tkeep[j]        = 1'b0;
            end
         end
         s_axis_tlast  = (b == nb - 1);
         s_axis_tvalid = 1'b1;
         if (b == abort_beat) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk(!m_axis_tvalid, "rst_mid_valid", m_axis_tvalid, 0);
            chk(!m_axis_tlast, "rst_mid_last", m_axis_tlast, 0);
            chk(!s_axis_tready, "rst_mid_ready", s_axis_tready, 0);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            exp_q.delete();
            exp_fwd  = 0;
            exp_drop = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk(s_axis_tready, "rst_mid_ready_rise", s_axis_tready, 1);
            return;
         end
         hs     = 1'b0;
         budget = 0;
         while (!hs) begin
            @(negedge clk);
            hs = s_axis_tready;
            if (!hs) stalls++;
            @(posedge clk);
            #1;
            budget++;
            if (!hs && budget > 500) begin
               chk(1'b0, "s_ready_timeout", s_axis_tready, 1);
               s_axis_tvalid = 1'b0;
               return;
            end
         end
         if (lat_chk && nb > 1 && b == 0) chk(!m_axis_tvalid, "lat_early", m_axis_tvalid, 0);
         if (lat_chk && b == lat_beat) chk(m_axis_tvalid, "lat_first", m_axis_tvalid, 1);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (beats > 0) exp_fwd++;
      else exp_drop++;
   endtask

   task automatic chk_stats();
`ifdef AXIS_IPV4_EXTRACT_STATS_EN
      chk(stat_fwd_cnt == exp_fwd, "stat_fwd", stat_fwd_cnt, exp_fwd);
      chk(stat_drop_cnt == exp_drop, "stat_drop", stat_drop_cnt, exp_drop);
`endif
   endtask

   initial begin
      int st;
      //           len  ethertype  seed pct beats last nostall
      vecs[0]  = '{142, 16'h0800, 1, 100, 2, 64, 1'b0};
      vecs[1]  = '{414, 16'h0800, 2, 100, 7, 16, 1'b0};
      vecs[2]  = '{60,  16'h0800, 3, 100, 1, 46, 1'b0};
      vecs[3]  = '{14,  16'h0800, 4, 100, 0, 0,  1'b1};
      vecs[4]  = '{192, 16'h86DD, 5, 100, 0, 0,  1'b1};
      vecs[5]  = '{142, 16'h0800, 6, 100, 2, 64, 1'b0};
      vecs[6]  = '{128, 16'h0800, 7, 100, 2, 50, 1'b0};
      vecs[7]  = '{64,  16'h0800, 8, 100, 1, 50, 1'b0};
      vecs[8]  = '{15,  16'h0800, 9, 100, 1, 1,  1'b0};
      vecs[9]  = '{78,  16'h0800, 10, 100, 1, 64, 1'b0};
      vecs[10] = '{60,  16'h0801, 11, 100, 0, 0,  1'b1};
      vecs[11] = '{142, 16'h0008, 12, 100, 0, 0,  1'b1};
      vecs[12] = '{79,  16'h0800, 13, 100, 2, 1,  1'b0};
      vecs[13] = '{142, 16'h0800, 1, 50,  2, 64, 1'b0};
      vecs[14] = '{414, 16'h0800, 2, 50,  7, 16, 1'b0};

      rst_n         = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(!m_axis_tvalid, "rst_valid", m_axis_tvalid, 0);
      chk(!m_axis_tlast, "rst_last", m_axis_tlast, 0);
      chk(m_axis_tdata == '0, "rst_data", m_axis_tdata, 0);
      chk(m_axis_tkeep == '0, "rst_keep", m_axis_tkeep, 0);
      chk(!s_axis_tready, "rst_ready", s_axis_tready, 0);
      chk_stats();
      rst_n = 1'b1;
      #1;
      chk(!s_axis_tready, "ready_before_edge", s_axis_tready, 0);
      @(posedge clk);
      #1;
      chk(s_axis_tready, "ready_after_edge", s_axis_tready, 1);

      for (int v = 0; v < 15; v++) begin
         rdy_pct = vecs[v].pct;
         send_frame(vecs[v].len, vecs[v].et, vecs[v].seed, vecs[v].beats,
                    vecs[v].last_bytes, (vecs[v].pct == 100) && (vecs[v].beats > 0), -1, st);
         if (vecs[v].nostall) chk(st == 0, "drop_no_stall", st, 0);
      end
      rdy_pct = 100;
      wait_drain();
      chk(!m_axis_tvalid, "idle_after_table", m_axis_tvalid, 0);
      chk_stats();

      // Reset while beat 3 of a 414-byte frame is offered, then a clean frame.
      send_frame(414, 16'h0800, 2, 7, 16, 1'b1, 2, st);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk(!m_axis_tvalid, "post_rst_quiet", m_axis_tvalid, 0);
      chk_stats();
      send_frame(142, 16'h0800, 1, 2, 64, 1'b1, -1, st);
      wait_drain();
      chk_stats();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_eth_ipv4_extractor.md
Name: axis_eth_ipv4_extractor

Overview:
Stage that sits directly upstream of the AXI4 IPv4 packet writer. Takes raw Ethernet frames on an AXI-Stream input and checks the EtherType. IPv4 frames (0x0800) are forwarded with the 14-byte Ethernet header stripped, re-aligned so that the first IPv4 header byte lands at tdata[7:0] of the first output beat. All other frames are consumed and dropped.

Parameters:
DATA_WIDTH, 512, stream width in bits; must be a multiple of 8 and at least 128.
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width (BEAT_BYTES).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous assert, active-low
s_axis_tdata  input  DATA_WIDTH  Ethernet frame data; byte i at tdata[8i+7:8i]
s_axis_tkeep  input  KEEP_WIDTH  byte enables; contiguous from LSB; all-ones except on the tlast beat
s_axis_tvalid  input  1  input beat valid
s_axis_tready  output  1  input beat accept
s_axis_tlast  input  1  last beat of frame
m_axis_tdata  output  DATA_WIDTH  IPv4 packet data, byte 0 = IP version/IHL
m_axis_tkeep  output  KEEP_WIDTH  output byte enables, contiguous from LSB
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  downstream accept
m_axis_tlast  output  1  last beat of IPv4 packet

Behaviour:
- Reset (rst_n=0, async): state IDLE; s_axis_tready=0; m_axis_tvalid/tlast=0; m_axis_tdata/tkeep=0; hold register cleared. s_axis_tready rises the first cycle after reset release.
- EtherType is bytes 12..13 of the first beat, big-endian: {tdata[103:96], tdata[111:104]}.
- Hold register H: 50 bytes = bytes 14..63 of the previous input beat. Output beat = {current beat bytes 0..13, H} (H occupies the low bytes).
- One-deep registered output. s_axis_tready = (!m_axis_tvalid || m_axis_tready) in IDLE/FWD; forced 1 in DROP; forced 0 in FLUSH.
- Let k = popcount(s_axis_tkeep) on the tlast beat.
- States:
  - IDLE: on accepted first beat:
    - EtherType != 0x0800, or (tlast && k <= 14): go to DROP, or stay in IDLE if tlast.
    - tlast && k > 14: emit one beat, tkeep = k-14 LSBs, tlast=1; stay in IDLE.
    - Otherwise: load H, go to FWD. No output this beat.
  - FWD: on each accepted beat:
    - Non-last: emit full beat (tkeep all-ones), reload H.
    - Last with k <= 14: emit beat with 50+k bytes, tlast=1; go to IDLE.
    - Last with k > 14: emit full beat, tlast=0; load H with bytes 14..k-1; go to FLUSH.
  - FLUSH: when the output register is free, emit H with tkeep = k-14 LSBs, tlast=1; go to IDLE.
  - DROP: accept every beat, produce no output; on tlast go to IDLE.
- Latency: the first output beat is valid the cycle after the second input beat is accepted (single-beat frame: the cycle after acceptance).
- Output beats hold their tdata/tkeep/tlast stable while tvalid=1 && tready=0.
- Simultaneous m_axis_tready and a new input beat in the same cycle: the register is replaced with no bubble, giving a throughput of 1 beat/cycle.
- Total output bytes = input frame bytes - 14, exactly.
- Reset mid-frame: the partial frame is discarded with no output tlast. Upstream is reset together with this block.
- Non-contiguous tkeep, or a tkeep other than all-ones on a non-last beat: undefined.

Optional Feature:
Macro AXIS_IPV4_EXTRACT_STATS_EN.
- With it: adds ports stat_fwd_cnt (output, 32) and stat_drop_cnt (output, 32).
  - stat_fwd_cnt increments once per forwarded frame, when its input tlast beat is accepted.
  - stat_drop_cnt increments on the accepted tlast beat of a DROP frame, or of a runt single-beat frame.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- Without it: the ports and counters are absent; datapath behaviour is identical.

Test Plan:
- 142-byte IPv4 frame, 3 beats, last k=14, m_axis_tready=1 -> 2 output beats, both tkeep all-ones, tlast on the 2nd; the 128 output bytes equal input bytes 14..141.
- 414-byte IPv4 frame (IP total length 400 at output bytes 2..3 = 0x01,0x90), 7 beats, last k=30 -> 7 output beats: 6 full, then FLUSH beat with tkeep 16 LSBs, tlast=1; total 400 bytes.
- 60-byte single-beat IPv4 frame -> one output beat, tkeep 46 LSBs, tlast=1. Separately, a 14-byte single-beat frame -> no output; stat_drop_cnt +1.
- 3-beat frame with EtherType 0x86DD -> s_axis_tready held 1 for all 3 beats, no m_axis_tvalid; stat_drop_cnt=1, stat_fwd_cnt=0. The next 0x0800 frame forwards normally.
- Back-to-back 142- and 414-byte frames with m_axis_tready random at 50% -> output byte stream identical to the no-backpressure runs; no tdata change while stalled; stat_fwd_cnt=2.
- rst_n pulsed low for 2 cycles during beat 3 of the 414-byte frame -> m_axis_tvalid=0 immediately. The next 142-byte frame outputs exactly as in the first scenario.
